// File: rtl/l1_l2_port_arbiter.sv
// l1_l2_port_arbiter
//   Shares the single L2 request port between the split L1 I-cache and D-cache.
//   Accepts one request at a time while idle, issues it as a line-aligned L2
//   transaction, waits for the L2 acknowledge (with a timeout), then pulses the
//   response back to the requester. L2 inclusivity evictions are forwarded to
//   the D-cache as a one-cycle invalidate pulse.
//
// Ports
//   clk, rst_n                          clock (rising edge), synchronous active-low reset
//   i_req_valid/addr, i_req_ready       I-cache fill request handshake
//   i_resp_valid                        one-cycle pulse: I fill complete
//   d_req_valid/addr/wb, d_req_ready    D-cache read fill (wb=0) or dirty write-back (wb=1)
//   d_resp_valid                        one-cycle pulse: D transaction complete
//   l2_req_valid/addr/we/src,
//   l2_req_ready, l2_ack                L2 request port and completion acknowledge
//   l2_evict_valid/addr, l2_evict_ready L2 eviction command handshake
//   d_evict_valid/addr                  one-cycle invalidate pulse to the D-cache
//   timeout_err                         sticky: an L2 transaction was never acknowledged
//   i_grant_cnt, d_grant_cnt            saturating per-source grant counters
module l1_l2_port_arbiter #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int BYTE_SELECT_WIDTH = 6,
  parameter int TIMEOUT_CYCLES    = 64,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  output logic                     i_req_ready,
  output logic                     i_resp_valid,
  input  logic                     d_req_valid,
  input  logic [ADDRESS_WIDTH-1:0] d_req_addr,
  input  logic                     d_req_wb,
  output logic                     d_req_ready,
  output logic                     d_resp_valid,
  output logic                     l2_req_valid,
  output logic [ADDRESS_WIDTH-1:0] l2_req_addr,
  output logic                     l2_req_we,
  output logic                     l2_req_src,
  input  logic                     l2_req_ready,
  input  logic                     l2_ack,
  input  logic                     l2_evict_valid,
  input  logic [ADDRESS_WIDTH-1:0] l2_evict_addr,
  output logic                     l2_evict_ready,
  output logic                     d_evict_valid,
  output logic [ADDRESS_WIDTH-1:0] d_evict_addr,
  output logic                     timeout_err,
  output logic [CNT_WIDTH-1:0]     i_grant_cnt,
  output logic [CNT_WIDTH-1:0]     d_grant_cnt
);

  localparam int AW = ADDRESS_WIDTH;
  // Timer only needs to reach TIMEOUT_CYCLES-1: the last WAIT_ACK cycle.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [AW-1:0] LINE_MASK =
    {{(AW-BYTE_SELECT_WIDTH){1'b1}}, {BYTE_SELECT_WIDTH{1'b0}}};
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, RESP, EVICT} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 we_q, we_d;
  logic                 src_q, src_d;
  logic                 last_src_q, last_src_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [AW-1:0]        evict_addr_q, evict_addr_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [CNT_WIDTH-1:0] i_cnt_q, i_cnt_d;
  logic [CNT_WIDTH-1:0] d_cnt_q, d_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      we_q          <= 1'b0;
      src_q         <= SRC_I;
      last_src_q    <= SRC_D;  // so the I-cache wins the first read tie
      timer_q       <= '0;
      evict_addr_q  <= '0;
      timeout_err_q <= 1'b0;
      i_cnt_q       <= '0;
      d_cnt_q       <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      src_q         <= src_d;
      last_src_q    <= last_src_d;
      timer_q       <= timer_d;
      evict_addr_q  <= evict_addr_d;
      timeout_err_q <= timeout_err_d;
      i_cnt_q       <= i_cnt_d;
      d_cnt_q       <= d_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    we_d           = we_q;
    src_d          = src_q;
    last_src_d     = last_src_q;
    timer_d        = timer_q;
    evict_addr_d   = evict_addr_q;
    timeout_err_d  = timeout_err_q;
    i_cnt_d        = i_cnt_q;
    d_cnt_d        = d_cnt_q;
    i_req_ready    = 1'b0;
    d_req_ready    = 1'b0;
    l2_evict_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        // No handshakes while reset is asserted: the reset would discard the
        // accepted request, so the requester must not see a ready for it.
        if (rst_n) begin
          if (l2_evict_valid) begin
            l2_evict_ready = 1'b1;
            evict_addr_d   = l2_evict_addr & LINE_MASK;
            state_d        = EVICT;
          end else if (d_req_valid &&
                       (d_req_wb || !i_req_valid || last_src_q == SRC_I)) begin
            // Write-backs always beat I fills; D reads win only on their turn.
            d_req_ready = 1'b1;
            addr_d      = d_req_addr & LINE_MASK;
            we_d        = d_req_wb;
            src_d       = SRC_D;
            last_src_d  = SRC_D;
            if (d_cnt_q != '1) d_cnt_d = d_cnt_q + CNT_WIDTH'(1);
            state_d     = ISSUE;
          end else if (i_req_valid) begin
            i_req_ready = 1'b1;
            addr_d      = i_req_addr & LINE_MASK;
            we_d        = 1'b0;
            src_d       = SRC_I;
            last_src_d  = SRC_I;
            if (i_cnt_q != '1) i_cnt_d = i_cnt_q + CNT_WIDTH'(1);
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (l2_req_ready) begin
          timer_d = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // An ack in the final allowed cycle still completes normally.
        if (l2_ack) begin
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP:    state_d = IDLE;
      EVICT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign l2_req_valid  = (state_q == ISSUE);
  assign l2_req_addr   = addr_q;
  assign l2_req_we     = we_q;
  assign l2_req_src    = src_q;
  assign i_resp_valid  = (state_q == RESP) && (src_q == SRC_I);
  assign d_resp_valid  = (state_q == RESP) && (src_q == SRC_D);
  assign d_evict_valid = (state_q == EVICT);
  assign d_evict_addr  = evict_addr_q;
  assign timeout_err   = timeout_err_q;
  assign i_grant_cnt   = i_cnt_q;
  assign d_grant_cnt   = d_cnt_q;

endmodule

// File: tb/tb_l1_l2_port_arbiter.sv
// tb_l1_l2_port_arbiter
//   Scoreboard bench for l1_l2_port_arbiter. Each batch loads request lists for
//   the I-cache, D-cache and L2 eviction drivers; a reference model derives the
//   service order from the arbitration rules and pushes the expected L2
//   requests, responses and eviction pulses into a queue. A monitor pops and
//   compares whenever the DUT presents one of those outputs.
`timescale 1ns/1ps
module tb_l1_l2_port_arbiter;

  localparam int AW      = 32;
  localparam int TO      = 4;
  localparam int CW      = 3;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int K_REQ   = 0;
  localparam int K_RESP  = 1;
  localparam int K_EVICT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_valid, i_req_ready, i_resp_valid;
  logic [AW-1:0] i_req_addr;
  logic          d_req_valid, d_req_wb, d_req_ready, d_resp_valid;
  logic [AW-1:0] d_req_addr;
  logic          l2_req_valid, l2_req_we, l2_req_src, l2_req_ready, l2_ack;
  logic [AW-1:0] l2_req_addr;
  logic          l2_evict_valid, l2_evict_ready, d_evict_valid;
  logic [AW-1:0] l2_evict_addr, d_evict_addr;
  logic          timeout_err;
  logic [CW-1:0] i_grant_cnt, d_grant_cnt;

  always #5 clk = ~clk;

  l1_l2_port_arbiter #(
    .ADDRESS_WIDTH(AW), .BYTE_SELECT_WIDTH(6), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wb(d_req_wb),
    .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid),
    .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_we(l2_req_we),
    .l2_req_src(l2_req_src), .l2_req_ready(l2_req_ready), .l2_ack(l2_ack),
    .l2_evict_valid(l2_evict_valid), .l2_evict_addr(l2_evict_addr),
    .l2_evict_ready(l2_evict_ready), .d_evict_valid(d_evict_valid),
    .d_evict_addr(d_evict_addr), .timeout_err(timeout_err),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  typedef struct { int kind; logic src; logic we; logic [AW-1:0] addr; } ev_t;
  typedef struct { logic [AW-1:0] addr; logic wb; } dreq_t;

  ev_t           exp_q[$];
  logic [AW-1:0] iq[$];
  dreq_t         dq[$];
  logic [AW-1:0] eq[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit ack_en   = 1'b1;
  int ack_delay = -1;

  // Reference model state
  int m_last_src = 1;
  int m_cnt_i    = 0;
  int m_cnt_d    = 0;
  int m_to_err   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return (a >> 6) << 6;  // 64-byte lines
  endfunction

  function automatic void model_reset();
    m_last_src = 1;
    m_cnt_i    = 0;
    m_cnt_d    = 0;
    m_to_err   = 0;
  endfunction

  function automatic void push_d(input logic [AW-1:0] a, input logic wb);
    dreq_t r;
    r.addr = a;
    r.wb   = wb;
    dq.push_back(r);
  endfunction

  function automatic void push_txn(input int src, input logic we, input logic [AW-1:0] a, input bit aen);
    ev_t e;
    e = '{kind: K_REQ, src: (src != 0), we: we, addr: line_of(a)};
    exp_q.push_back(e);
    if (src != 0) m_cnt_d = (m_cnt_d < CNT_MAX) ? m_cnt_d + 1 : CNT_MAX;
    else          m_cnt_i = (m_cnt_i < CNT_MAX) ? m_cnt_i + 1 : CNT_MAX;
    if (aen) begin
      e.kind = K_RESP;
      exp_q.push_back(e);
    end else begin
      m_to_err = 1;
    end
    m_last_src = src;
  endfunction

  // Service order: evictions first, then write-backs, then I/D reads alternating.
  function automatic void model_batch(input bit aen);
    logic [AW-1:0] mi[$];
    dreq_t         md[$];
    logic [AW-1:0] me[$];
    ev_t           e;
    bit            take_d;
    mi = iq;
    md = dq;
    me = eq;
    while (mi.size() + md.size() + me.size() > 0) begin
      if (me.size() > 0) begin
        e = '{kind: K_EVICT, src: 1'b0, we: 1'b0, addr: line_of(me.pop_front())};
        exp_q.push_back(e);
      end else begin
        take_d = (md.size() > 0) && (md[0].wb || mi.size() == 0 || m_last_src == 0);
        if (take_d) begin
          push_txn(1, md[0].wb, md[0].addr, aen);
          void'(md.pop_front());
        end else begin
          push_txn(0, 1'b0, mi.pop_front(), aen);
        end
      end
    end
  endfunction

  task automatic pop_expected(input int kind, output ev_t e, output bit ok);
    e  = '{kind: -1, src: 1'b0, we: 1'b0, addr: '0};
    ok = 1'b0;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got event kind %0d, required none", kind);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        n_fail++;
        $display("FAIL event_kind: got kind %0d, required kind %0d", kind, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard.
  initial begin : monitor
    ev_t e;
    bit  ok;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (int'(i_req_valid) + int'(d_req_valid) + int'(l2_evict_valid) > 1)
          check("ready_onehot", $countones({i_req_ready, d_req_ready, l2_evict_ready}) <= 1, 1);
        if (l2_req_valid && l2_req_ready) begin
          $display("[%0t] l2 request src=%0d we=%0d addr=%08h", $time, l2_req_src, l2_req_we, l2_req_addr);
          pop_expected(K_REQ, e, ok);
          if (ok) begin
            check("l2_req_src", l2_req_src, e.src);
            check("l2_req_we", l2_req_we, e.we);
            check("l2_req_addr", l2_req_addr, e.addr);
          end
        end
        if (i_resp_valid || d_resp_valid) begin
          $display("[%0t] response i=%0d d=%0d", $time, i_resp_valid, d_resp_valid);
          check("resp_onehot", i_resp_valid & d_resp_valid, 0);
          pop_expected(K_RESP, e, ok);
          if (ok) check("resp_src", d_resp_valid, e.src);
        end
        if (d_evict_valid) begin
          $display("[%0t] d-cache evict addr=%08h", $time, d_evict_addr);
          pop_expected(K_EVICT, e, ok);
          if (ok) check("d_evict_addr", d_evict_addr, e.addr);
        end
      end
    end
  end

  // L2 model: random request-ready delay, ack within the allowed window
  // (including the final cycle), stray acks while nothing is outstanding.
  initial begin : l2_responder
    int d;
    l2_req_ready = 1'b0;
    l2_ack       = 1'b0;
    forever begin
      @(posedge clk); #1;
      l2_ack = 1'b0;
      if (rst_n && l2_req_valid) begin
        d = $urandom_range(0, 2);
        repeat (d) begin @(posedge clk); #1; end
        l2_req_ready = 1'b1;
        @(posedge clk); #1;
        l2_req_ready = 1'b0;
        if (ack_en && rst_n) begin
          d = (ack_delay >= 0) ? ack_delay : $urandom_range(0, TO - 1);
          repeat (d) begin @(posedge clk); #1; end
          l2_ack = 1'b1;
          @(posedge clk); #1;
          l2_ack = 1'b0;
        end
      end else if (ack_en && $urandom_range(0, 7) == 0) begin
        l2_ack = 1'b1;
      end
    end
  end

  task automatic drive_i();
    int guard;
    while (iq.size() > 0) begin
      i_req_addr  = iq[0];
      i_req_valid = 1'b1;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!i_req_ready && guard < 300);
      if (!i_req_ready) begin
        check("i_req_ready_wait", i_req_ready, 1);
        iq.delete();
      end else begin
        @(posedge clk); #1;
        void'(iq.pop_front());
      end
    end
    i_req_valid = 1'b0;
  endtask

  task automatic drive_d();
    int guard;
    while (dq.size() > 0) begin
      d_req_addr  = dq[0].addr;
      d_req_wb    = dq[0].wb;
      d_req_valid = 1'b1;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!d_req_ready && guard < 300);
      if (!d_req_ready) begin
        check("d_req_ready_wait", d_req_ready, 1);
        dq.delete();
      end else begin
        @(posedge clk); #1;
        void'(dq.pop_front());
      end
    end
    d_req_valid = 1'b0;
    d_req_wb    = 1'b0;
  endtask

  task automatic drive_e();
    int guard;
    while (eq.size() > 0) begin
      l2_evict_addr  = eq[0];
      l2_evict_valid = 1'b1;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!l2_evict_ready && guard < 300);
      if (!l2_evict_ready) begin
        check("l2_evict_ready_wait", l2_evict_ready, 1);
        eq.delete();
      end else begin
        @(posedge clk); #1;
        void'(eq.pop_front());
      end
    end
    l2_evict_valid = 1'b0;
  endtask

  task automatic run_batch(input bit aen);
    int guard;
    ack_en = aen;
    model_batch(aen);
    fork
      drive_i();
      drive_d();
      drive_e();
    join
    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin @(posedge clk); guard++; end
    check("events_outstanding", exp_q.size(), 0);
    exp_q.delete();
    repeat (TO + 3) @(posedge clk);
    #1;
    check("i_grant_cnt", i_grant_cnt, m_cnt_i);
    check("d_grant_cnt", d_grant_cnt, m_cnt_d);
    check("timeout_err", timeout_err, m_to_err);
    check("idle_after_batch", l2_req_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_l2_req_ctl"}, {l2_req_valid, l2_req_we, l2_req_src}, 0);
    check({tag, "_l2_req_addr"}, l2_req_addr, 0);
    check({tag, "_pulses"}, {i_resp_valid, d_resp_valid, d_evict_valid, timeout_err}, 0);
    check({tag, "_d_evict_addr"}, d_evict_addr, 0);
    check({tag, "_grant_cnts"}, {i_grant_cnt, d_grant_cnt}, 0);
    check({tag, "_readies"}, {i_req_ready, d_req_ready, l2_evict_ready}, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check_all_zero("reset");
    model_reset();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_l2_handshake(input string name);
    int g;
    g = 0;
    do begin @(negedge clk); g++; end while (!(l2_req_valid && l2_req_ready) && g < 100);
    check(name, l2_req_valid && l2_req_ready, 1);
  endtask

  // timeout_err must rise after exactly TO unacknowledged WAIT_ACK cycles.
  task automatic timeout_timing();
    wait_l2_handshake("timeout_handshake");
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      check("timeout_timing", timeout_err, (k == TO + 1));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n_i, n_d, n_e;
    rst_n = 1'b0;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_wb = 1'b0;
    l2_evict_valid = 1'b0; l2_evict_addr = '0;
    @(posedge clk); #1;

    // Reset held 3 cycles, then 5 idle cycles with no L2 request.
    do_reset(3);
    repeat (5) begin
      @(negedge clk);
      check("idle_no_l2_req", l2_req_valid, 0);
    end
    @(posedge clk); #1;

    // Single I fill, fixed ack latency.
    ack_delay = 2;
    iq.push_back(32'h1234_5678);
    run_batch(1'b1);
    ack_delay = -1;

    // I and D reads both pending: I, D, I, D.
    do_reset(2);
    iq.push_back(32'h0000_1000); iq.push_back(32'h0000_1040);
    push_d(32'h0000_2000, 1'b0); push_d(32'h0000_2040, 1'b0);
    run_batch(1'b1);

    // Write-back beats a simultaneous I request.
    do_reset(2);
    push_d(32'h0000_0FC0, 1'b1);
    iq.push_back(32'h0000_4444);
    run_batch(1'b1);

    // Eviction beats a pending D read.
    do_reset(2);
    eq.push_back(32'hABCD_0040);
    push_d(32'h0000_8008, 1'b0);
    run_batch(1'b1);

    // No ack: timeout after TO cycles, no response, next request still served.
    do_reset(2);
    iq.push_back(32'h0000_2000);
    fork
      run_batch(1'b0);
      timeout_timing();
    join
    iq.push_back(32'h0000_3000);
    run_batch(1'b1);

    // Reset in the middle of a transaction clears everything, no response.
    iq.push_back(32'h5555_1234);
    ack_en = 1'b0;
    model_batch(1'b0);
    fork
      drive_i();
    join_none
    wait_l2_handshake("midreset_handshake");
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("midreset");
    model_reset();
    exp_q.delete();
    rst_n = 1'b1;
    repeat (TO + 4) @(posedge clk);
    #1;
    check("midreset_no_timeout", timeout_err, 0);
    check("midreset_idle", l2_req_valid, 0);

    // Randomized batches; counters saturate at CNT_MAX along the way.
    for (int b = 0; b < 40; b++) begin
      n_i = $urandom_range(0, 2);
      n_d = $urandom_range(0, 2);
      n_e = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      for (int k = 0; k < n_i; k++) iq.push_back($urandom());
      for (int k = 0; k < n_d; k++) push_d($urandom(), 1'($urandom_range(0, 1)));
      for (int k = 0; k < n_e; k++) eq.push_back($urandom());
      if (n_i + n_d + n_e == 0) iq.push_back($urandom());
      run_batch($urandom_range(0, 7) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
